mul_arbiter: RTL and testbench
==============================

MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; the product width is 2*WIDTH.
REQ-002 The block SHALL have parameter TIMEOUT, default 64, giving the maximum WAIT-state cycles before an error completion.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Port: clk  input  1  rising-edge clock for all state.
REQ-005 Port: reset  input  1  synchronous active-high reset.
REQ-006 Port: req_valid  input  4  per-requester request strobe, one bit per requester 0..3.
REQ-007 Port: req_ready  output  4  per-requester accept, at most one bit high, combinational.
REQ-008 Port: req_a  input  4*WIDTH  packed multipliers; requester i uses bits [i*WIDTH +: WIDTH].
REQ-009 Port: req_b  input  4*WIDTH  packed multiplicands, same packing as req_a.
REQ-010 Port: resp_valid  output  4  one-hot single-cycle completion pulse to the owning requester.
REQ-011 Port: resp_product  output  2*WIDTH  product of the completed request.
REQ-012 Port: resp_err  output  1  high with resp_valid when the completion timed out.
REQ-013 Port: mul_start  output  1  start strobe to the shared multiplier.
REQ-014 Port: mul_multiplier  output  WIDTH  operand A to the multiplier.
REQ-015 Port: mul_multiplicand  output  WIDTH  operand B to the multiplier.
REQ-016 Port: mul_product  input  2*WIDTH  multiplier result.
REQ-017 Port: mul_ready  input  1  multiplier idle flag; low while a multiply runs.
REQ-018 Port: busy  output  1  high in every state except IDLE.

Function
REQ-019 States SHALL be IDLE, ISSUE and WAIT.
REQ-020 IDLE: when mul_ready=1 and any req_valid bit is set, raise req_ready for the round-robin winner in the same cycle, latch its operands and id, and go to ISSUE.
REQ-021 IDLE with mul_ready=0: req_ready SHALL stay 0 and the state SHALL stay IDLE.
REQ-022 Round-robin search SHALL start at (last_grant+1) mod 4 and wrap 3->0; last_grant updates only on an accept.
REQ-023 ISSUE: mul_start=1 for exactly one cycle with the latched operands; clear seen_busy and the wait counter; go to WAIT.
REQ-024 mul_start SHALL be 0 in every state other than ISSUE; the operand outputs hold the latched values at all times.
REQ-025 WAIT: set seen_busy on any cycle with mul_ready=0.
REQ-026 WAIT: on a cycle with mul_ready=1 and seen_busy=1, register mul_product into resp_product, pulse resp_valid[id] with resp_err=0 on the next cycle, and go to IDLE.
REQ-027 WAIT: a mul_ready=1 cycle with seen_busy=0 SHALL NOT complete the request; this guards against a multiplier that never leaves ready.
REQ-028 The wait counter SHALL increment on every WAIT cycle.
REQ-029 When the wait counter reaches TIMEOUT with no completion, the block SHALL pulse resp_valid[id] with resp_err=1 and resp_product=0, then go to IDLE.
REQ-030 Nominal latency with a WIDTH-cycle multiplier: accept at cycle T, mul_start at T+1, resp_valid at T+WIDTH+3.
REQ-031 resp_valid SHALL be high for exactly one cycle per accepted request; resp_product and resp_err SHALL hold until the next completion.
REQ-032 The block SHALL hold at most one outstanding request; no req_ready in ISSUE or WAIT.
REQ-033 A requester that deasserts req_valid before acceptance SHALL lose its turn with no side effects.
REQ-034 A request whose req_valid stays high after completion SHALL be treated as a new request.

Reset
REQ-035 On reset: state=IDLE, last_grant=3 (requester 0 first), wait counter=0, seen_busy=0.
REQ-036 On reset: req_ready=0, resp_valid=0, resp_err=0, resp_product=0, mul_start=0, operand outputs=0, busy=0.
REQ-037 A reset during ISSUE or WAIT SHALL abandon the request with no resp_valid.
REQ-038 After reset, the block SHALL accept no new request until mul_ready=1, since the multiplier itself has no reset.

Verification
REQ-039 Single request: req_valid=0001, a=7, b=6, bench multiplier with WIDTH busy cycles -> req_ready=0001 at T, resp_valid=0001 at T+35 (WIDTH=32), product=42, err=0.
REQ-040 Contention: all four req_valid held high after reset -> grants in order 0,1,2,3,0; each resp_valid matches its grant.
REQ-041 Wide operands: a=b=0xFFFFFFFF -> resp_product=0xFFFFFFFE00000001.
REQ-042 Stuck multiplier: mul_ready held 1 for the whole run -> no early completion; resp_valid with resp_err=1 and product=0 after TIMEOUT WAIT cycles.
REQ-043 Reset mid-WAIT with mul_ready low for 10 more cycles -> no resp_valid; req_ready stays 0 until mul_ready=1; next grant goes to requester 0.
REQ-044 Drop before accept: req_valid[2] pulsed while mul_ready=0 -> no grant and no response for requester 2.

Source files
------------

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one multi-cycle multiplier between four requesters.
// Latency: accept at T, mul_start at T+1, resp_valid at T+WIDTH+3 for a WIDTH-cycle multiplier.
// Backpressure: req_ready is raised only in IDLE with mul_ready=1; one request is outstanding at a time.
module mul_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           req_valid,
    output logic [3:0]           req_ready,
    input  logic [4*WIDTH-1:0]   req_a,
    input  logic [4*WIDTH-1:0]   req_b,
    output logic [3:0]           resp_valid,
    output logic [2*WIDTH-1:0]   resp_product,
    output logic                 resp_err,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_multiplier,
    output logic [WIDTH-1:0]     mul_multiplicand,
    input  logic [2*WIDTH-1:0]   mul_product,
    input  logic                 mul_ready,
    output logic                 busy
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [1:0]      last_grant;
    logic [1:0]      cur_id;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [CW-1:0]   wait_cnt;
    logic            seen_busy;

    logic            rr_found;
    logic [1:0]      rr_winner;
    logic            accept;
    logic            done_ok;
    logic            done_to;

    // Round-robin search starting one past the last accepted requester, wrapping 3->0.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = last_grant;
        for (int i = 1; i <= 4; i++) begin
            if (!rr_found && req_valid[last_grant + 2'(i)]) begin
                rr_found  = 1'b1;
                rr_winner = last_grant + 2'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode; completion wins over timeout on the same cycle.
    always_comb begin
        state_nxt = state;
        req_ready = 4'b0000;
        accept    = 1'b0;
        done_ok   = 1'b0;
        done_to   = 1'b0;
        case (state)
            S_IDLE: begin
                // The multiplier has no reset, so nothing is accepted until it reports idle.
                if (!reset && mul_ready && rr_found) begin
                    req_ready[rr_winner] = 1'b1;
                    accept               = 1'b1;
                    state_nxt            = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A ready seen before any busy cycle is stale and must not complete the request.
                if (mul_ready && seen_busy) begin
                    done_ok   = 1'b1;
                    state_nxt = S_IDLE;
                end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    done_to   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign mul_start        = (state == S_ISSUE);
    assign busy             = (state != S_IDLE);
    assign mul_multiplier   = op_a;
    assign mul_multiplicand = op_b;

    // Latch the winner's id and operands on accept; they drive the multiplier until the next accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 2'd3;
            cur_id     <= 2'd0;
            op_a       <= '0;
            op_b       <= '0;
        end else if (accept) begin
            last_grant <= rr_winner;
            cur_id     <= rr_winner;
            op_a       <= req_a[rr_winner*WIDTH +: WIDTH];
            op_b       <= req_b[rr_winner*WIDTH +: WIDTH];
        end
    end

    // Wait-cycle counter and busy observation, both restarted when the multiply is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt  <= '0;
            seen_busy <= 1'b0;
        end else if (state == S_ISSUE) begin
            wait_cnt  <= '0;
            seen_busy <= 1'b0;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (!mul_ready) begin
                seen_busy <= 1'b1;
            end
        end
    end

    // Registered completion: one-cycle resp_valid pulse, product/err held until the next completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid   <= 4'b0000;
            resp_product <= '0;
            resp_err     <= 1'b0;
        end else begin
            resp_valid <= 4'b0000;
            if (done_ok) begin
                resp_valid   <= 4'b0001 << cur_id;
                resp_product <= mul_product;
                resp_err     <= 1'b0;
            end else if (done_to) begin
                resp_valid   <= 4'b0001 << cur_id;
                resp_product <= '0;
                resp_err     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: table of request vectors plus hand sequences for contention,
// stuck multiplier, drop-before-accept and reset mid-WAIT.
// Expected grants/products/latencies come from the tables and a scoreboard queue.
module tb_mul_arbiter;

    localparam int W  = 32;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      req_valid;
    logic [3:0]      req_ready;
    logic [4*W-1:0]  req_a;
    logic [4*W-1:0]  req_b;
    logic [3:0]      resp_valid;
    logic [2*W-1:0]  resp_product;
    logic            resp_err;
    logic            mul_start;
    logic [W-1:0]    mul_multiplier;
    logic [W-1:0]    mul_multiplicand;
    logic [2*W-1:0]  mul_product;
    logic            mul_ready;
    logic            busy;

    mul_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_a            (req_a),
        .req_b            (req_b),
        .resp_valid       (resp_valid),
        .resp_product     (resp_product),
        .resp_err         (resp_err),
        .mul_start        (mul_start),
        .mul_multiplier   (mul_multiplier),
        .mul_multiplicand (mul_multiplicand),
        .mul_product      (mul_product),
        .mul_ready        (mul_ready),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: busy for W cycles after a start; no reset, like the real unit.
    logic        m_ready = 1'b1;
    int          m_cnt = 0;
    logic [63:0] m_prod = '0;
    logic        stuck = 1'b0;
    logic        force_busy = 1'b0;
    assign mul_ready   = m_ready & ~force_busy;
    assign mul_product = m_prod;

    always @(posedge clk) begin
        if (stuck) begin
            m_ready <= 1'b1;
            m_prod  <= 64'h0BAD_0BAD_0BAD_0BAD;
        end else if (m_ready && mul_start) begin
            m_ready <= 1'b0;
            m_cnt   <= W;
            m_prod  <= {32'd0, mul_multiplier} * {32'd0, mul_multiplicand};
        end else if (!m_ready) begin
            if (m_cnt == 1) m_ready <= 1'b1;
            m_cnt <= m_cnt - 1;
        end
    end

    typedef struct {
        logic [3:0]  vld;
        logic [63:0] prod;
        logic        err;
        int          cyc;
    } resp_exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
    } start_exp_t;

    resp_exp_t  resp_q[$];
    start_exp_t start_q[$];
    int         exp_grant_q[$];

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int rsp_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Monitors: accepts feed the scoreboard; starts and responses are popped and compared.
    always @(negedge clk) begin
        int gid;
        resp_exp_t  re;
        start_exp_t se;
        if (|req_ready) begin
            acc_cnt++;
            gid = 0;
            for (int i = 3; i >= 0; i--) if (req_ready[i]) gid = i;
            chk("grant_onehot_in_valid", {63'd0, ($onehot(req_ready) && ((req_ready & ~req_valid) == 4'b0))}, 64'd1);
            chk("accept_needs_mul_ready", {63'd0, mul_ready}, 64'd1);
            if (exp_grant_q.size() == 0) begin
                chk("unexpected_grant", {60'd0, req_ready}, 64'd0);
            end else begin
                chk("grant_id", gid, exp_grant_q.pop_front());
            end
            se.a   = req_a[gid*W +: W];
            se.b   = req_b[gid*W +: W];
            se.cyc = cyc + 1;
            start_q.push_back(se);
            re.vld  = 4'b0001 << gid;
            re.err  = stuck;
            re.prod = stuck ? 64'd0 : ({32'd0, se.a} * {32'd0, se.b});
            re.cyc  = cyc + (stuck ? TO + 2 : W + 3);
            resp_q.push_back(re);
        end
        if (mul_start) begin
            if (start_q.size() == 0) begin
                chk("unexpected_mul_start", {63'd0, mul_start}, 64'd0);
            end else begin
                se = start_q.pop_front();
                chk("start_cycle", cyc, se.cyc);
                chk("start_op_a", mul_multiplier, se.a);
                chk("start_op_b", mul_multiplicand, se.b);
                chk("busy_in_issue", {63'd0, busy}, 64'd1);
            end
        end
        if (|resp_valid) begin
            rsp_cnt++;
            if (resp_q.size() == 0) begin
                chk("unexpected_resp", {60'd0, resp_valid}, 64'd0);
            end else begin
                re = resp_q.pop_front();
                chk("resp_valid", resp_valid, re.vld);
                chk("resp_product", resp_product, re.prod);
                chk("resp_err", resp_err, re.err);
                chk("resp_cycle", cyc, re.cyc);
            end
        end
    end

    task automatic wait_accept(input int target, input int budget, input string name);
        int k = 0;
        while (acc_cnt < target && k < budget) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (acc_cnt < target) chk({name, "_accept_timeout"}, acc_cnt, target);
    endtask

    task automatic wait_resp(input int target, input int budget, input string name);
        int k = 0;
        while (rsp_cnt < target && k < budget) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (rsp_cnt < target) chk({name, "_resp_timeout"}, rsp_cnt, target);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 4'b0000;
        resp_q.delete();
        start_q.delete();
        exp_grant_q.delete();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0]   mask;
        logic [127:0] a;
        logic [127:0] b;
        int           grant;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int base;
        // {mask, a3..a0, b3..b0, expected grant}; last_grant starts at 3.
        vecs[0] = '{4'b0001, {32'd0, 32'd0, 32'd0, 32'd7}, {32'd0, 32'd0, 32'd0, 32'd6}, 0};
        vecs[1] = '{4'b0001, {32'd0, 32'd0, 32'd0, 32'hFFFFFFFF}, {32'd0, 32'd0, 32'd0, 32'hFFFFFFFF}, 0};
        vecs[2] = '{4'b0110, {32'd0, 32'd100, 32'd3, 32'd0}, {32'd0, 32'd200, 32'd5, 32'd0}, 1};
        vecs[3] = '{4'b0110, {32'd0, 32'd100, 32'd3, 32'd0}, {32'd0, 32'd200, 32'd5, 32'd0}, 2};
        vecs[4] = '{4'b1001, {32'h12345678, 32'd0, 32'd0, 32'd11}, {32'h9ABCDEF0, 32'd0, 32'd0, 32'd13}, 3};
        vecs[5] = '{4'b1111, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd8, 32'd7, 32'd6, 32'd5}, 0};

        reset     = 1'b1;
        req_valid = 4'b0000;
        req_a     = '0;
        req_b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_resp_product", resp_product, 0);
        chk("rst_mul_start", mul_start, 0);
        chk("rst_op_a", mul_multiplier, 0);
        chk("rst_op_b", mul_multiplicand, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Table-driven single requests: grant order, products, nominal latency.
        for (int r = 0; r < 6; r++) begin
            base = acc_cnt;
            exp_grant_q.push_back(vecs[r].grant);
            req_a     = vecs[r].a;
            req_b     = vecs[r].b;
            req_valid = vecs[r].mask;
            wait_accept(base + 1, 100, "vec");
            req_valid = 4'b0000;
            wait_resp(base + 1, 100, "vec");
        end

        // Contention: all four held high after reset -> 0,1,2,3,0.
        do_reset();
        base = acc_cnt;
        foreach (exp_grant_q[i]) exp_grant_q.delete(i);
        exp_grant_q.push_back(0);
        exp_grant_q.push_back(1);
        exp_grant_q.push_back(2);
        exp_grant_q.push_back(3);
        exp_grant_q.push_back(0);
        req_a     = {32'd40, 32'd30, 32'd20, 32'd10};
        req_b     = {32'd4, 32'd3, 32'd2, 32'd1};
        req_valid = 4'b1111;
        wait_accept(base + 5, 400, "contention");
        req_valid = 4'b0000;
        wait_resp(rsp_cnt >= base + 5 ? rsp_cnt : base + 5, 100, "contention");

        // Stuck multiplier: ready never drops -> timeout completion with err=1, product=0.
        stuck = 1'b1;
        base  = acc_cnt;
        exp_grant_q.push_back(2);
        req_a     = {32'd0, 32'd9, 32'd0, 32'd0};
        req_b     = {32'd0, 32'd9, 32'd0, 32'd0};
        req_valid = 4'b0100;
        wait_accept(base + 1, 20, "stuck");
        req_valid = 4'b0000;
        wait_resp(rsp_cnt + 1, TO + 20, "stuck");
        stuck = 1'b0;
        @(posedge clk);
        #2;

        // Drop before accept: requester 2 pulses while the multiplier is busy.
        force_busy = 1'b1;
        base       = acc_cnt;
        req_valid  = 4'b0100;
        repeat (3) begin
            @(negedge clk);
            chk("drop_no_grant", req_ready, 0);
        end
        @(posedge clk);
        #2;
        req_valid  = 4'b0000;
        force_busy = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        chk("drop_no_accept", acc_cnt, base);

        // Reset mid-WAIT: request abandoned, no grant while mul_ready is low, then requester 0 wins.
        base = acc_cnt;
        exp_grant_q.push_back(1);
        req_a     = {32'd0, 32'd0, 32'd5, 32'd0};
        req_b     = {32'd0, 32'd0, 32'd5, 32'd0};
        req_valid = 4'b0010;
        wait_accept(base + 1, 20, "midwait");
        req_valid = 4'b0000;
        repeat (10) @(posedge clk);
        #2;
        chk("midwait_busy", busy, 1);
        force_busy = 1'b1;
        do_reset();
        base      = rsp_cnt;
        req_a     = {32'd17, 32'd16, 32'd15, 32'd14};
        req_b     = {32'd3, 32'd3, 32'd3, 32'd3};
        req_valid = 4'b1111;
        repeat (10) begin
            @(negedge clk);
            chk("postrst_no_grant", req_ready, 0);
            chk("postrst_idle", busy, 0);
        end
        chk("postrst_no_resp", rsp_cnt, base);
        exp_grant_q.push_back(0);
        @(posedge clk);
        #2;
        force_busy = 1'b0;
        wait_accept(acc_cnt + 1, 60, "postrst");
        req_valid = 4'b0000;
        wait_resp(rsp_cnt + 1, 100, "postrst");

        repeat (5) @(posedge clk);
        #2;
        chk("pending_resp", resp_q.size(), 0);
        chk("pending_grant", exp_grant_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
